// File: rtl/ds4_pkg.sv
// Shared select encoding for the ds4_mux 4:1 datapath selector.
package ds4_pkg;

  typedef logic [1:0] ds4_sel_t;

  localparam ds4_sel_t SEL_D1 = 2'd0;
  localparam ds4_sel_t SEL_D2 = 2'd1;
  localparam ds4_sel_t SEL_D3 = 2'd2;
  localparam ds4_sel_t SEL_D4 = 2'd3;

endpackage

// File: rtl/ds4_mux_if.sv
// Operand bundle for ds4_mux: four candidates and a select in, the chosen word out.
interface ds4_mux_if #(
  parameter int WIDTH = 32
);
  import ds4_pkg::*;

  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [WIDTH-1:0] data4;
  ds4_sel_t         select;
  logic [WIDTH-1:0] out;

  modport master (output data1, data2, data3, data4, select, input out);
  modport slave  (input data1, data2, data3, data4, select, output out);

endinterface

// File: rtl/ds4_mux2.sv
// WIDTH-bit 2:1 mux leaf used to build the balanced selection tree in ds4_mux.
module ds4_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/ds4_mux.sv
// 4:1 datapath selector with an X-guard on select; define DS4_OUT_REG_EN to
// register the output (1-cycle latency, synchronous active-high rst).
module ds4_mux
  import ds4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  ds4_mux_if.slave  bus
);

  logic [WIDTH-1:0] w_stage1_lo;
  logic [WIDTH-1:0] w_stage1_hi;
  logic [WIDTH-1:0] w_tree;
  logic [WIDTH-1:0] w_sel_out;

  ds4_mux2 #(.WIDTH(WIDTH)) u_mux_lo (
    .i_a   (bus.data1),
    .i_b   (bus.data2),
    .i_sel (bus.select[0]),
    .o_y   (w_stage1_lo)
  );

  ds4_mux2 #(.WIDTH(WIDTH)) u_mux_hi (
    .i_a   (bus.data3),
    .i_b   (bus.data4),
    .i_sel (bus.select[0]),
    .o_y   (w_stage1_hi)
  );

  ds4_mux2 #(.WIDTH(WIDTH)) u_mux_root (
    .i_a   (w_stage1_lo),
    .i_b   (w_stage1_hi),
    .i_sel (bus.select[1]),
    .o_y   (w_tree)
  );

  // An X/Z select misses every case item and lands on the zero default, keeping
  // X out of the datapath; synthesis sees the default as unreachable.
  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    w_sel_out = '0;
    case (bus.select)
      SEL_D1, SEL_D2, SEL_D3, SEL_D4: w_sel_out = w_tree;
      default:                        w_sel_out = '0;
    endcase
  end

`ifdef DS4_OUT_REG_EN
  logic [WIDTH-1:0] r_out;

  // NOTE: non-blocking assignment for registered state avoids evaluation-order races.
  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_sel_out;
  end

  assign bus.out = r_out;
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = &{1'b0, clk, rst};

  assign bus.out = w_sel_out;
`endif

endmodule

// File: tb/tb_ds4_mux.sv
// Directed self-checking bench for ds4_mux; also covers the DS4_OUT_REG_EN build.
module tb_ds4_mux;
  import ds4_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ds4_mux_if #(.WIDTH(WIDTH)) bus ();

  ds4_mux #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] d4,
                       input logic [1:0] sel);
    bus.data1  = d1;
    bus.data2  = d2;
    bus.data3  = d3;
    bus.data4  = d4;
    bus.select = sel;
  endtask

  // Registered build: sample one edge later; combinational build: after a hold.
  task automatic settle(input int hold_ns);
`ifdef DS4_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #(hold_ns);
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (bus.out === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, bus.out, exp);
    end
  endtask

  function automatic logic [31:0] ref_sel(input logic [1:0] sel,
                                          input logic [31:0] d1, input logic [31:0] d2,
                                          input logic [31:0] d3, input logic [31:0] d4);
    if ($isunknown(sel)) return 32'h0;
    case (sel)
      2'd0:    return d1;
      2'd1:    return d2;
      2'd2:    return d3;
      default: return d4;
    endcase
  endfunction

  initial begin
    logic [31:0] pat;
    logic [31:0] exp;
    logic [31:0] d [4];
    logic [1:0]  xsel;

    drive(32'h0, 32'h0, 32'h0, 32'h0, SEL_D1);
`ifdef DS4_OUT_REG_EN
    bus.data1 = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'h0);
    drive(32'h0, 32'h0, 32'h0, 32'h0, SEL_D1);
`endif
    rst = 1'b0;

    // 1. all zero
    settle(10);
    check("all_zero", 32'h0);

    // 2. first pattern, select 0
    drive(32'h33, 32'hF0, 32'h0F, 32'h55, SEL_D1);
    settle(10);
    check("pat1_sel0", 32'h0000_0033);

    // 3. new data, select stepping with 100 ns holds
    drive(32'hFF, 32'hEF, 32'h81, 32'hCC, SEL_D1);
    settle(100);
    check("pat2_sel0", 32'h0000_00FF);
    bus.select = SEL_D2;
    settle(100);
    check("pat2_sel1", 32'h0000_00EF);
    bus.select = SEL_D3;
    settle(100);
    check("pat2_sel2", 32'h0000_0081);
    bus.select = SEL_D4;
    settle(100);
    check("pat2_sel3", 32'h0000_00CC);

    // simultaneous data and select change yields new data on the new source
    drive(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, SEL_D2);
    settle(10);
    check("simul_change", 32'h2222_2222);

    // 4. walking one and all-ones per source; other sources must read zero
    for (int src = 0; src < 4; src++) begin
      for (int b = 0; b <= WIDTH; b++) begin
        pat = (b == WIDTH) ? 32'hFFFF_FFFF : (32'h1 << b);
        for (int k = 0; k < 4; k++) d[k] = (k == src) ? pat : 32'h0;
        for (int s = 0; s < 4; s++) begin
          drive(d[0], d[1], d[2], d[3], s[1:0]);
          settle(10);
          exp = (s == src) ? pat : 32'h0;
          check($sformatf("walk_src%0d_b%0d_sel%0d", src, b, s), exp);
        end
      end
    end

    // 5. unknown select forces zero (2-state simulators resolve X to a legal code)
    xsel = 2'bxx;
    drive(32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h3C3C_3C3C, xsel);
    settle(10);
    check("sel_unknown", ref_sel(bus.select, bus.data1, bus.data2, bus.data3, bus.data4));

`ifdef DS4_OUT_REG_EN
    // 6. reset, first post-reset load, mid-stream reset discards pending value
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'hCC, SEL_D4);
    repeat (2) @(posedge clk);
    #1;
    check("reg_reset", 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reg_first_load", 32'h0000_00CC);
    drive(32'h11, 32'h0, 32'h0, 32'hCC, SEL_D1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reg_mid_reset", 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reg_after_reset", 32'h0000_0011);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
